// File: rtl/cmp_rr_sched_pkg.sv
// Shared constants and FSM encoding for the round-robin comparator scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmp_rr_sched_pkg;

  localparam int N_REQ_DEF = 4;  // default number of requesters
  localparam int ID_W_DEF  = 2;  // default requester ID width
  localparam int OPW       = 4;  // operand width of the shared comparator

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_rr_sched_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping to 0.
// Latency: combinational.
// Backpressure: none; the caller decides whether the pick is taken.
// Ports: req vector, ptr start index; gnt one-hot, gnt_idx binary, any = |req.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  int j;

  // Walk offsets from farthest to nearest so the nearest set bit overrides.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    j       = 0;
    any     = |req;
    for (int k = N - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % N;
      if (req[j]) begin
        gnt     = '0;
        gnt[j]  = 1'b1;
        gnt_idx = IW'(j);
      end
    end
  end

endmodule

// File: rtl/mag_cmp4.sv
// 4-bit unsigned magnitude comparator, the single shared compare resource.
// Latency: combinational.
// Backpressure: none.
// Ports: a, b operands; eq = a==b, gt = a>b, sm = a<b.
module mag_cmp4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       eq,
  output logic       gt,
  output logic       sm
);

  assign eq = (a == b);
  assign gt = (a >  b);
  assign sm = (a <  b);

endmodule

// File: rtl/cmp_rr_sched.sv
// Round-robin scheduler sharing one 4-bit comparator among N_REQ requesters.
// Latency: accept to rsp_valid is 2 cycles; issue interval 3 cycles minimum.
// Backpressure: rsp held until rsp_ready; no new grant while a result is pending.
// Ports: clk, rst (sync, active high); req_valid/req_a/req_b in, req_ready one-hot out;
//        rsp_valid/rsp_id/rsp_eq/rsp_gt/rsp_sm out, rsp_ready in.
// Build option: CMP_SIGNED_EN selects two's-complement operand ordering.
module cmp_rr_sched
  import cmp_rr_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int ID_W  = ID_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [OPW*N_REQ-1:0] req_a,
  input  logic [OPW*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_eq,
  output logic                 rsp_gt,
  output logic                 rsp_sm
);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    gnt_id;
  logic [OPW-1:0]     op_a, op_b;
  logic [OPW-1:0]     sel_a, sel_b;
  logic [OPW-1:0]     cmp_a, cmp_b;
  logic [N_REQ-1:0]   pick_gnt;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               c_eq, c_gt, c_sm;
  logic               take, load_rsp, done;

  rr_pick #(.N(N_REQ), .IW(ID_W)) u_pick (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_a = req_a[i*OPW +: OPW];
        sel_b = req_b[i*OPW +: OPW];
      end
    end
  end

`ifdef CMP_SIGNED_EN
  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign cmp_a = {~op_a[OPW-1], op_a[OPW-2:0]};
  assign cmp_b = {~op_b[OPW-1], op_b[OPW-2:0]};
`else
  assign cmp_a = op_a;
  assign cmp_b = op_b;
`endif

  mag_cmp4 u_cmp (
    .a  (cmp_a),
    .b  (cmp_b),
    .eq (c_eq),
    .gt (c_gt),
    .sm (c_sm)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    take      = 1'b0;
    load_rsp  = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_gnt;
          take      = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
        load_rsp  = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        // rsp_valid is always high here, so rsp_ready alone completes it.
        if (rsp_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      gnt_id    <= '0;
      op_a      <= '0;
      op_b      <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_eq    <= 1'b0;
      rsp_gt    <= 1'b0;
      rsp_sm    <= 1'b0;
    end else begin
      if (take) begin
        op_a   <= sel_a;
        op_b   <= sel_b;
        gnt_id <= pick_idx;
      end
      if (load_rsp) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt_id;
        rsp_eq    <= c_eq;
        rsp_gt    <= c_gt;
        rsp_sm    <= c_sm;
      end
      if (done) begin
        rsp_valid <= 1'b0;
        if (gnt_id == ID_W'(N_REQ - 1)) ptr <= '0;
        else                            ptr <= gnt_id + ID_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cmp_rr_sched.sv
// Self-checking bench for cmp_rr_sched with a transaction-level reference model.
// Latency: n/a.
// Backpressure: rsp_ready is driven both held and randomized.
module tb_cmp_rr_sched;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [4*N-1:0] req_a, req_b;
  logic [N-1:0]  req_ready;
  logic          rsp_valid, rsp_ready;
  logic [1:0]    rsp_id;
  logic          rsp_eq, rsp_gt, rsp_sm;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  cmp_rr_sched #(.N_REQ(N), .ID_W(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_eq    (rsp_eq),
    .rsp_gt    (rsp_gt),
    .rsp_sm    (rsp_sm)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  int         cyc = 0;
  bit         m_busy = 1'b0;
  int         m_ptr = 0;
  int         m_id = 0;
  int         m_acc = 0;
  logic [3:0] m_a = '0, m_b = '0;

  function automatic int winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      int j;
      j = (p + k) % N;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  function automatic int as_num(input logic [3:0] x);
    int r;
    r = int'(x);
`ifdef CMP_SIGNED_EN
    if (x[3]) r = r - 16;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
    end else if (!m_busy) begin
      w = winner(req_valid, m_ptr);
      if (w >= 0) begin
        m_busy = 1'b1;
        m_id   = w;
        m_a    = req_a[4*w +: 4];
        m_b    = req_b[4*w +: 4];
        m_acc  = cyc;
      end
    end else if (cyc >= m_acc + 2 && rsp_ready) begin
      m_busy = 1'b0;
      m_ptr  = (m_id + 1) % N;
    end
    cyc = cyc + 1;
  end

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic         exp_rv;
    int           w, sa, sb;
    if (chk_en) begin
      exp_rdy = '0;
      if (!m_busy) begin
        w = winner(req_valid, m_ptr);
        if (w >= 0) exp_rdy[w] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      exp_rv = m_busy && (cyc >= m_acc + 2);
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      if (exp_rv) begin
        sa = as_num(m_a);
        sb = as_num(m_b);
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_eq", 32'(rsp_eq), 32'(sa == sb));
        check("rsp_gt", 32'(rsp_gt), 32'(sa > sb));
        check("rsp_sm", 32'(rsp_sm), 32'(sa < sb));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    req_valid = '0;
    step();
    rst = 1'b0;
  endtask

  int ids[$];
  int when[$];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b0;
    step();
    step();
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_flags", 32'({rsp_eq, rsp_gt, rsp_sm}), 32'd0);
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    // Single request from req 1: 9 vs 3.
    req_valid = 4'b0010; req_a = 16'h0090; req_b = 16'h0030; rsp_ready = 1'b1;
    @(negedge clk);
    check("t1_ready", 32'(req_ready), 32'b0010);
    step(); req_valid = '0;
    step();
    @(negedge clk);
    check("t1_valid", 32'(rsp_valid), 32'd1);
    check("t1_id", 32'(rsp_id), 32'd1);
    check("t1_flags", 32'({rsp_eq, rsp_gt, rsp_sm}), 32'b010);
    step();

    // All four continuously valid with equal operands.
    pulse_rst();
    req_valid = 4'hF; req_a = 16'h5555; req_b = 16'h5555; rsp_ready = 1'b1;
    for (int n = 0; n < 40 && ids.size() < 5; n++) begin
      @(negedge clk);
      if (rsp_valid) begin
        ids.push_back(int'(rsp_id));
        when.push_back(n);
        check("t3_eq", 32'(rsp_eq), 32'd1);
      end
      step();
    end
    check("t3_count", 32'(ids.size()), 32'd5);
    for (int i = 0; i < 5 && i < ids.size(); i++)
      check("t3_order", 32'(ids[i]), 32'(exp_order[i]));
    for (int i = 1; i < when.size(); i++)
      check("t3_interval", 32'(when[i] - when[i-1]), 32'd3);
    req_valid = '0;
    step(); step(); step();

    // Backpressure: req 3 computes 1 vs 4, consumer stalls 5 cycles.
    pulse_rst();
    req_valid = 4'b1000; req_a = 16'h1006; req_b = 16'h4006; rsp_ready = 1'b0;
    step(); req_valid = 4'b0001;
    step();
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      check("t4_hold_valid", 32'(rsp_valid), 32'd1);
      check("t4_hold_id", 32'(rsp_id), 32'd3);
      check("t4_hold_flags", 32'({rsp_eq, rsp_gt, rsp_sm}), 32'b001);
      check("t4_hold_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    @(negedge clk);
    check("t4_next_grant", 32'(req_ready), 32'b0001);
    step(); req_valid = '0;
    step(); step(); step();

    // Wrap-around: last grant req 2, then only req 0 with 2 vs 7.
    pulse_rst();
    req_valid = 4'b0100; req_a = 16'h0100; req_b = 16'h0100;
    step(); req_valid = '0;
    step(); step();
    req_valid = 4'b0001; req_a = 16'h0002; req_b = 16'h0007;
    @(negedge clk);
    check("t5_wrap_grant", 32'(req_ready), 32'b0001);
    step(); req_valid = '0;
    step();
    @(negedge clk);
    check("t5_id", 32'(rsp_id), 32'd0);
    check("t5_sm", 32'(rsp_sm), 32'd1);
    step();

    // Reset during CMP, then a fresh request from req 2.
    req_valid = 4'b0010; req_a = 16'h0030; req_b = 16'h0010;
    step(); req_valid = '0; rst = 1'b1;
    step(); rst = 1'b0;
    @(negedge clk);
    check("t6_valid", 32'(rsp_valid), 32'd0);
    check("t6_ready", 32'(req_ready), 32'd0);
    step();
    req_valid = 4'b0101; req_a = 16'h0a00; req_b = 16'h0a00;
    @(negedge clk);
    check("t6_ptr_cleared", 32'(req_ready), 32'b0001);
    step(); req_valid = 4'b0100;
    step(); step();
    @(negedge clk);
    check("t6_req2_grant", 32'(req_ready), 32'b0100);
    step(); req_valid = '0;
    step();
    @(negedge clk);
    check("t6_req2_eq", 32'(rsp_eq), 32'd1);
    step();

    // Sign handling: -8 vs 7 (or 8 vs 7 unsigned).
    req_valid = 4'b0001; req_a = 16'h0008; req_b = 16'h0007;
    step(); req_valid = '0;
    step();
    @(negedge clk);
`ifdef CMP_SIGNED_EN
    check("t7_flags", 32'({rsp_eq, rsp_gt, rsp_sm}), 32'b001);
`else
    check("t7_flags", 32'({rsp_eq, rsp_gt, rsp_sm}), 32'b010);
`endif
    step();

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 3000; n++) begin
      req_valid = 4'($urandom);
      req_a = 16'($urandom);
      req_b = ($urandom % 4 == 0) ? req_a : 16'($urandom);
      rsp_ready = ($urandom % 4) != 0;
      rst = ($urandom % 200) == 0;
      step();
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    step(); step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmp_rr_sched.md
Name: cmp_rr_sched

Overview:
- Round-robin scheduler that shares one 4-bit magnitude comparator (Eq/Gt/Sm outputs) between N_REQ requesters.
- Each requester presents an operand pair (A, B) with a valid/ready handshake.
- The block grants one requester at a time, sequences the compare, and returns a registered Eq/Gt/Sm result tagged with the requester ID over a valid/ready response channel.
- Sits between client blocks and the single comparator instance.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 2, width of the requester ID; must equal ceil(log2(N_REQ)).

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N_REQ  per-requester request valid.
- req_a  input  4*N_REQ  operand A; requester i occupies bits [4i+3:4i].
- req_b  input  4*N_REQ  operand B; same packing as req_a.
- req_ready  output  N_REQ  one-hot accept strobe; requester i's operands are captured in the cycle req_valid[i] & req_ready[i].
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  index of the requester that owns the result.
- rsp_eq, rsp_gt, rsp_sm  output  1 each  A==B, A>B, A<B; exactly one is high whenever rsp_valid=1.

Behaviour:
- Reset values: all outputs 0; FSM = IDLE; RR pointer = 0; operand registers = 0.
- FSM IDLE:
  - If any req_valid is set, the winner is the first set bit at or after the RR pointer, searching upward with wrap-around.
  - req_ready[winner]=1 combinationally in this cycle; all other req_ready bits are 0.
  - Operands and ID are latched; next state is CMP.
  - If no req_valid is set, stay in IDLE with req_ready=0.
- FSM CMP: the latched operands drive the comparator. Eq/Gt/Sm are registered into rsp_*, rsp_valid is set, next state is RESP. req_ready=0.
- FSM RESP:
  - Hold rsp_valid, rsp_id and the result flags stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid deasserts next cycle, RR pointer = granted ID + 1 (wrapping N_REQ-1 -> 0), next state is IDLE.
  - req_ready=0 throughout RESP.
- Latency: accept-to-rsp_valid is 2 cycles. Minimum issue interval is 3 cycles when rsp_ready is held high.
- Fairness: a continuously valid requester is granted within N_REQ grants.
- Requesters may change or drop req_valid in any cycle. Only the handshake cycle matters; operands are not resampled after capture.
- rsp_ready asserted while rsp_valid=0 is ignored.
- Reset asserted in any state returns to IDLE next edge, drops any in-flight result, and clears the pointer. rst has priority over every handshake in the same cycle.
- Pointer wrap-around: with pointer=N_REQ-1 and only req 0 valid, req 0 is granted.

Optional Feature:
- Macro: CMP_SIGNED_EN.
- Defined: operands are two's complement (-8..7). Bit 3 of both A and B is inverted before the comparator, so Gt/Sm reflect signed order. Eq is unaffected.
- Undefined: unsigned compare (0..15). No extra logic.

Decomposition:
- Shared package/header: FSM state encodings IDLE=2'd0, CMP=2'd1, RESP=2'd2; N_REQ/ID_W defaults; the operand width constant (4).
- Natural sub-module: rr_pick. Combinational round-robin picker with inputs req vector and pointer, outputs one-hot grant, grant index and any-valid.
- The comparator is instantiated once, unchanged.

Test Plan:
- Single request: req 1 valid, A=4'd9, B=4'd3, rsp_ready=1.
  - Expected: req_ready=4'b0010 at accept; 2 cycles later rsp_valid=1, rsp_id=1, gt=1, eq=0, sm=0.
- All four requesters valid continuously, each with A=B=4'd5.
  - Expected: grant order 0,1,2,3,0; every response has eq=1; one response per 3 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid.
  - Expected: rsp_* held stable, req_ready stays 0; after rsp_ready=1 the next grant appears 1 cycle after the IDLE return.
- Wrap-around: pointer=3 (last grant was req 2), only req 0 valid with A=4'd2, B=4'd7.
  - Expected: req 0 granted, sm=1.
- Reset mid-operation: rst=1 in the CMP cycle.
  - Expected: next cycle rsp_valid=0, req_ready=0, pointer=0; a fresh request from req 2 is granted normally.
- CMP_SIGNED_EN defined: A=4'b1000 (-8), B=4'b0111 (7).
  - Expected: sm=1. Without the macro the same stimulus gives gt=1.
